mux2_rr_arbiter: RTL

Two-requester round-robin arbiter that shares a single 2:1 data mux and its output channel between two sources. It owns the mux select, grants one requester at a time, and forwards the granted data over a valid/ready output handshake. Bursts are bounded by a per-grant transfer limit, so neither port can starve the other. It is the sequencing front end for the gate-level 2:1 mux datapath.

---
 rtl/mux2_rr_arbiter_if.sv | 48 ++++
 rtl/mux2_rr_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if
// Bundles the requester, output-channel and status signals of the two-port
// round-robin arbiter so they can be passed as one port.
//   slave  : arbiter side. It samples req0/req1, d0/d1 and out_ready, and
//            drives gnt0/gnt1, sel, out_valid, out_data and busy.
//   master : requester/consumer side, with the opposite directions.
// When MUX_ARB_CNT_EN is defined, the bundle also carries the cnt_clr input
// and the 16-bit per-port transfer counters cnt0/cnt1.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy;
`ifdef MUX_ARB_CNT_EN
  logic             cnt_clr;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;
`endif

`ifdef MUX_ARB_CNT_EN
  modport slave (
    input  req0, req1, d0, d1, out_ready, cnt_clr,
    output gnt0, gnt1, sel, out_valid, out_data, busy, cnt0, cnt1
  );
  modport master (
    output req0, req1, d0, d1, out_ready, cnt_clr,
    input  gnt0, gnt1, sel, out_valid, out_data, busy, cnt0, cnt1
  );
`else
  modport slave (
    input  req0, req1, d0, d1, out_ready,
    output gnt0, gnt1, sel, out_valid, out_data, busy
  );
  modport master (
    output req0, req1, d0, d1, out_ready,
    input  gnt0, gnt1, sel, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Two-requester round-robin arbiter. It owns the select of a shared 2:1 data
// mux and forwards the granted port's data over a valid/ready channel.
// Each grant is limited to MAX_BURST accepted transfers before the channel is
// handed over, so neither port can starve the other.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux2_rr_arbiter_if.slave
//           req0/req1 and d0/d1       requests and data from the two ports
//           gnt0/gnt1/sel/busy        registered grant, mux select and busy
//           out_valid/out_data        output channel; out_data = sel ? d1 : d0
//           out_ready                 downstream accept
// Optional feature (macro MUX_ARB_CNT_EN):
//   Adds 16-bit saturating per-port transfer counters (bus.cnt0, bus.cnt1)
//   and a synchronous clear input (bus.cnt_clr). The clear wins over a
//   transfer in the same cycle. Arbitration is identical in both builds.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux2_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // A release triggered by the burst limit fires on the transfer that
  // completes the burst, which is when the count still reads MAX_BURST-1.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t           state;
  state_t           next_state;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             sel_q;
  logic             busy_q;
  logic             last_q;
  logic [7:0]       burst_cnt;
  logic             out_valid;
  logic             transfer;
  logic             burst_done;
  logic             release_own;
  logic [WIDTH-1:0] mux_out;

  // The owner presents valid only while it keeps requesting. A withdrawn
  // request therefore drops valid in the same cycle.
  assign out_valid  = (gnt0_q & bus.req0) | (gnt1_q & bus.req1);
  assign transfer   = out_valid & bus.out_ready;
  assign burst_done = transfer && (burst_cnt == BURST_LAST);
  assign mux_out    = sel_q ? bus.d1 : bus.d0;

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mux_out;

  // Next-state decode. On release the other port takes over directly if it
  // is requesting. Otherwise the releasing port is re-granted when it still
  // requests, which happens after a burst-limit release.
  always_comb begin
    next_state  = state;
    release_own = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_q)) begin
          next_state = OWN0;
        end else if (bus.req1) begin
          next_state = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0 || burst_done) begin
          release_own = 1'b1;
          if (bus.req1) begin
            next_state = OWN1;
          end else if (bus.req0) begin
            next_state = OWN0;
          end else begin
            next_state = IDLE;
          end
        end
      end
      OWN1: begin
        if (!bus.req1 || burst_done) begin
          release_own = 1'b1;
          if (bus.req0) begin
            next_state = OWN0;
          end else if (bus.req1) begin
            next_state = OWN1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant, select and busy are registered copies of the next state, so they
  // change on the same edge as the state itself. The burst count clears on
  // every state entry, including a re-grant of the same port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b1;
      burst_cnt <= 8'd0;
    end else begin
      state  <= next_state;
      gnt0_q <= (next_state == OWN0);
      gnt1_q <= (next_state == OWN1);
      sel_q  <= (next_state == OWN1);
      busy_q <= (next_state != IDLE);
      if (next_state == OWN0) begin
        last_q <= 1'b0;
      end else if (next_state == OWN1) begin
        last_q <= 1'b1;
      end
      if (release_own || (next_state != state)) begin
        burst_cnt <= 8'd0;
      end else if (transfer) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

`ifdef MUX_ARB_CNT_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

  // Per-port accepted-transfer counters. sel identifies the source of a
  // transfer, and both counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else if (bus.cnt_clr) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      if (transfer && !sel_q && (cnt0_q != 16'hFFFF)) begin
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (transfer && sel_q && (cnt1_q != 16'hFFFF)) begin
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end
`endif

endmodule
